// File: rtl/memory_board_gen_if.sv
// Board-generator bus: control inputs (start/clear/window) and board outputs.
// With BOARD_GEN_SEED_PORT_EN defined it also carries the seed_load/seed pair.
// WIDTH must match the WIDTH of the memory_board_gen instance it connects to.
interface memory_board_gen_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             clear;
  logic [CW-1:0]    min_lit;
  logic [CW-1:0]    max_lit;
  logic [WIDTH-1:0] board;
  logic             board_valid;
  logic             busy;
  logic [CW-1:0]    lit_count;
  logic             fail;
`ifdef BOARD_GEN_SEED_PORT_EN
  logic             seed_load;
  logic [31:0]      seed;
`endif

  // Player/difficulty side: drives requests, observes the board.
  modport master (
    output start, clear, min_lit, max_lit,
`ifdef BOARD_GEN_SEED_PORT_EN
    output seed_load, seed,
`endif
    input  board, board_valid, busy, lit_count, fail
  );

  // Generator side.
  modport slave (
    input  start, clear, min_lit, max_lit,
`ifdef BOARD_GEN_SEED_PORT_EN
    input  seed_load, seed,
`endif
    output board, board_valid, busy, lit_count, fail
  );
endinterface

// File: rtl/memory_board_gen.sv
// Memory Matrix board generator. A free-running 32-bit Galois LFSR supplies
// one candidate board per cycle; candidates are rejected until the lit-tile
// count lands in the registered [emin, emax] window, with a deterministic
// fallback board after MAX_TRIES candidates or for an empty window.
// Optional macro BOARD_GEN_SEED_PORT_EN adds a runtime LFSR seed-load port.
module memory_board_gen #(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2468,
  parameter int          MAX_TRIES = 64
) (
  input logic               clk,
  input logic               reset,
  memory_board_gen_if.slave bus
);
  localparam int            CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_CW    = CW'(WIDTH);
  localparam logic [7:0]    MAX_TRIES_8 = 8'(MAX_TRIES);
  localparam logic [31:0]   LFSR_MASK   = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, ARMED, GEN, READY} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      lfsr_reg, lfsr_step;
  logic [WIDTH-1:0] board_reg, cand, fb_board;
  logic [CW-1:0]    lit_reg, cand_pop, fb_count;
  logic [CW-1:0]    emin_reg, emax_reg, emin_launch, emax_launch;
  logic [7:0]       tries_reg;
  logic             fail_reg;
  logic             window_bad, accept, last_try, go_fallback;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Right-shifting Galois step: bit 0 falls out and folds the tap mask back in.
  assign lfsr_step = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 32'h0);
  assign cand      = lfsr_reg[WIDTH-1:0];
  assign cand_pop  = popcount(cand);

  // Window clamped at launch: a zero minimum would allow an all-dark board.
  assign emin_launch = (bus.min_lit == '0) ? CW'(1) : bus.min_lit;
  assign emax_launch = (bus.max_lit > WIDTH_CW) ? WIDTH_CW : bus.max_lit;

  // Fallback board lights the lowest emin tiles (all tiles when emin >= WIDTH).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fallback
    assign fb_board[gi] = (CW'(gi) < emin_reg);
  end
  assign fb_count = (emin_reg > WIDTH_CW) ? WIDTH_CW : emin_reg;

  assign window_bad  = (emin_reg > emax_reg);
  assign accept      = !window_bad && (cand_pop >= emin_reg) && (cand_pop <= emax_reg);
  assign last_try    = ((tries_reg + 8'd1) == MAX_TRIES_8);
  assign go_fallback = window_bad || (!accept && last_try);

  // LFSR runs in every state; clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_reg <= SEED;
`ifdef BOARD_GEN_SEED_PORT_EN
    else if (bus.seed_load) lfsr_reg <= (bus.seed == 32'h0) ? SEED : bus.seed;
`endif
    else lfsr_reg <= lfsr_step;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; clear overrides every other request.
  always_comb begin
    state_next = state_reg;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start)  state_next = ARMED;
        ARMED:   if (!bus.start) state_next = GEN;
        GEN:     if (accept || go_fallback) state_next = READY;
        READY:   if (bus.start)  state_next = ARMED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Board datapath: window latch on launch, candidate accept or fallback in GEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_reg <= '0;
      lit_reg   <= '0;
      fail_reg  <= 1'b0;
      emin_reg  <= '0;
      emax_reg  <= '0;
      tries_reg <= '0;
    end else if (bus.clear) begin
      board_reg <= '0;
      lit_reg   <= '0;
      fail_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ARMED: begin
          if (!bus.start) begin
            emin_reg  <= emin_launch;
            emax_reg  <= emax_launch;
            tries_reg <= '0;
            fail_reg  <= 1'b0;
          end
        end
        GEN: begin
          if (accept) begin
            board_reg <= cand;
            lit_reg   <= cand_pop;
            fail_reg  <= 1'b0;
          end else if (go_fallback) begin
            board_reg <= fb_board;
            lit_reg   <= fb_count;
            fail_reg  <= 1'b1;
          end else begin
            tries_reg <= tries_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    bus.board_valid = (state_reg == READY);
    bus.busy        = (state_reg == ARMED) || (state_reg == GEN);
  end

  assign bus.board     = board_reg;
  assign bus.lit_count = lit_reg;
  assign bus.fail      = fail_reg;
endmodule

// File: tb/tb_memory_board_gen.sv
// Self-checking bench for memory_board_gen: randomized launches compared with
// a reference that scans LFSR candidates against the requested window.
module tb_memory_board_gen;
  localparam int          W     = 16;
  localparam int          CW    = 5;
  localparam logic [31:0] SEED  = 32'hACE1_2468;
  localparam logic [31:0] SEED2 = 32'h1234_5678;
  localparam int          MAXT  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_board_gen_if #(.WIDTH(W)) bus ();
  memory_board_gen_if #(.WIDTH(W)) bus2 ();

  memory_board_gen #(.WIDTH(W), .SEED(SEED), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  memory_board_gen #(.WIDTH(W), .SEED(SEED2), .MAX_TRIES(1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  function automatic logic [31:0] lstep(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [15:0] fallback_board(input int emin);
    logic [31:0] m;
    m = (32'd1 << emin) - 32'd1;
    return (emin >= W) ? 16'hFFFF : m[15:0];
  endfunction

  // Reference LFSR sequences for both instances.
  logic [31:0] m_lfsr, m2_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
`ifdef BOARD_GEN_SEED_PORT_EN
    else if (bus.seed_load) m_lfsr <= (bus.seed == 32'h0) ? SEED : bus.seed;
`endif
    else m_lfsr <= lstep(m_lfsr);
  end
  always @(posedge clk or posedge reset) begin
    if (reset) m2_lfsr <= SEED2;
    else       m2_lfsr <= lstep(m2_lfsr);
  end

  // Launch a generation on dut and report the reference outcome and the
  // observed latency (cycles from launch edge to board_valid, -1 on timeout).
  task automatic do_launch(input int mn, input int mx, input int press,
                           output logic [15:0] eb, output bit ef,
                           output int elat, output int olat);
    int emin, emax, p;
    logic [15:0] c;
    bus.min_lit = CW'(mn);
    bus.max_lit = CW'(mx);
    bus.start = 1'b1;
    repeat (press) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    emin = (mn < 1) ? 1 : mn;
    emax = (mx > W) ? W : mx;
    eb = '0; ef = 1'b0; elat = 0; olat = -1;
    for (int k = 1; k <= MAXT + 2; k++) begin
      if (elat == 0) begin
        c = m_lfsr[15:0];
        p = $countones(c);
        if (emin > emax) begin
          eb = fallback_board(emin); ef = 1'b1; elat = k;
        end else if (p >= emin && p <= emax) begin
          eb = c; ef = 1'b0; elat = k;
        end else if (k == MAXT) begin
          eb = fallback_board(emin); ef = 1'b1; elat = k;
        end
      end
      @(negedge clk);
      if (bus.board_valid && olat < 0) olat = k;
      if (olat >= 0 && elat != 0) break;
    end
    $display("launch min=%0d max=%0d board=%h lit=%0d fail=%0b lat=%0d (ref board=%h fail=%0b lat=%0d)",
             mn, mx, bus.board, bus.lit_count, bus.fail, olat, eb, ef, elat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (bus.board !== 16'h0) begin n_fail++; $display("FAIL reset_board: got %h want 0000", bus.board); end
    if (bus.board_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.board_valid); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.lit_count !== 5'd0) begin n_fail++; $display("FAIL reset_lit: got %0d want 0", bus.lit_count); end
    if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", bus.fail); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_board;
    logic [15:0] eb; bit ef; int elat, olat;
    do_launch(1, 16, 3, eb, ef, elat, olat);
    n_checks += 6;
    if (olat !== elat || elat != 1) begin n_fail++; $display("FAIL first_latency: got %0d want 1", olat); end
    if (bus.board !== eb) begin n_fail++; $display("FAIL first_board: got %h want %h", bus.board, eb); end
    if (bus.board === 16'h0) begin n_fail++; $display("FAIL first_nonzero: got %h want nonzero", bus.board); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL first_busy: got %b want 0", bus.busy); end
    if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL first_fail: got %b want 0", bus.fail); end
    if (bus.lit_count !== 5'($countones(eb))) begin n_fail++; $display("FAIL first_lit: got %0d want %0d", bus.lit_count, $countones(eb)); end
  endtask

  task automatic test_exact_window;
    logic [15:0] eb; bit ef; int elat, olat;
    for (int i = 0; i < 200; i++) begin
      do_launch(8, 8, int'($urandom_range(1, 4)), eb, ef, elat, olat);
      n_checks += 4;
      if (bus.board !== eb) begin n_fail++; $display("FAIL exact_board[%0d]: got %h want %h", i, bus.board, eb); end
      if (bus.lit_count !== 5'd8) begin n_fail++; $display("FAIL exact_lit[%0d]: got %0d want 8", i, bus.lit_count); end
      if (bus.fail !== ef) begin n_fail++; $display("FAIL exact_fail[%0d]: got %b want %b", i, bus.fail, ef); end
      if (olat !== elat) begin n_fail++; $display("FAIL exact_latency[%0d]: got %0d want %0d", i, olat, elat); end
    end
  endtask

  task automatic test_random_windows;
    logic [15:0] eb; bit ef; int elat, olat;
    for (int i = 0; i < 60; i++) begin
      do_launch(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(1, 3)), eb, ef, elat, olat);
      n_checks += 4;
      if (bus.board !== eb) begin n_fail++; $display("FAIL rand_board[%0d]: got %h want %h", i, bus.board, eb); end
      if (bus.lit_count !== 5'($countones(eb))) begin n_fail++; $display("FAIL rand_lit[%0d]: got %0d want %0d", i, bus.lit_count, $countones(eb)); end
      if (bus.fail !== ef) begin n_fail++; $display("FAIL rand_fail[%0d]: got %b want %b", i, bus.fail, ef); end
      if (olat !== elat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, olat, elat); end
    end
  endtask

  task automatic test_invalid_window;
    logic [15:0] eb; bit ef; int elat, olat;
    do_launch(10, 3, 2, eb, ef, elat, olat);
    n_checks += 4;
    if (bus.board !== 16'h03FF) begin n_fail++; $display("FAIL invalid_board: got %h want 03ff", bus.board); end
    if (bus.lit_count !== 5'd10) begin n_fail++; $display("FAIL invalid_lit: got %0d want 10", bus.lit_count); end
    if (bus.fail !== 1'b1) begin n_fail++; $display("FAIL invalid_fail: got %b want 1", bus.fail); end
    if (olat !== 1) begin n_fail++; $display("FAIL invalid_latency: got %0d want 1", olat); end
  endtask

  task automatic test_max_tries1;
    logic [15:0] c; bit ef;
    bus2.min_lit = 5'd16;
    bus2.max_lit = 5'd16;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    @(negedge clk);
    c = m2_lfsr[15:0];
    ef = (c != 16'hFFFF);
    @(negedge clk);
    $display("max_tries1 cand=%h board=%h fail=%0b valid=%0b", c, bus2.board, bus2.fail, bus2.board_valid);
    n_checks += 4;
    if (bus2.board_valid !== 1'b1) begin n_fail++; $display("FAIL mt1_valid: got %b want 1", bus2.board_valid); end
    if (bus2.board !== 16'hFFFF) begin n_fail++; $display("FAIL mt1_board: got %h want ffff", bus2.board); end
    if (bus2.fail !== ef) begin n_fail++; $display("FAIL mt1_fail: got %b want %b", bus2.fail, ef); end
    if (bus2.lit_count !== 5'd16) begin n_fail++; $display("FAIL mt1_lit: got %0d want 16", bus2.lit_count); end
  endtask

  task automatic test_clear;
    logic [15:0] eb; bit ef; int elat, olat;
    // clear while generating
    bus.min_lit = 5'd16; bus.max_lit = 5'd16; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    $display("clear_gen board=%h valid=%0b busy=%0b", bus.board, bus.board_valid, bus.busy);
    n_checks += 4;
    if (bus.board_valid !== 1'b0) begin n_fail++; $display("FAIL clr_gen_valid: got %b want 0", bus.board_valid); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_gen_busy: got %b want 0", bus.busy); end
    if (bus.board !== 16'h0) begin n_fail++; $display("FAIL clr_gen_board: got %h want 0000", bus.board); end
    if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL clr_gen_fail: got %b want 0", bus.fail); end
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_no_arm: got busy %b want 0", bus.busy); end
    // clear while READY
    do_launch(1, 16, 2, eb, ef, elat, olat);
    n_checks++;
    if (bus.board_valid !== 1'b1) begin n_fail++; $display("FAIL clr_pre_valid: got %b want 1", bus.board_valid); end
    bus.clear = 1'b1;
    @(negedge clk);
    $display("clear_ready board=%h valid=%0b lit=%0d", bus.board, bus.board_valid, bus.lit_count);
    n_checks += 3;
    if (bus.board_valid !== 1'b0) begin n_fail++; $display("FAIL clr_rdy_valid: got %b want 0", bus.board_valid); end
    if (bus.board !== 16'h0) begin n_fail++; $display("FAIL clr_rdy_board: got %h want 0000", bus.board); end
    if (bus.lit_count !== 5'd0) begin n_fail++; $display("FAIL clr_rdy_lit: got %0d want 0", bus.lit_count); end
    // clear together with start: clear wins, start must be seen again in IDLE
    bus.start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_start_busy: got %b want 0", bus.busy); end
    bus.clear = 1'b0;
    @(negedge clk);
    $display("clear_start release busy=%0b", bus.busy);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clr_rearm_busy: got %b want 1", bus.busy); end
    bus.start = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_gen;
    logic [15:0] eb; bit ef; int elat, olat;
    do_launch(1, 16, 1, eb, ef, elat, olat);
    bus.min_lit = 5'd16; bus.max_lit = 5'd16; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    $display("reset_mid_gen board=%h valid=%0b busy=%0b lit=%0d fail=%0b",
             bus.board, bus.board_valid, bus.busy, bus.lit_count, bus.fail);
    n_checks += 5;
    if (bus.board !== 16'h0) begin n_fail++; $display("FAIL rst_gen_board: got %h want 0000", bus.board); end
    if (bus.board_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gen_valid: got %b want 0", bus.board_valid); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_gen_busy: got %b want 0", bus.busy); end
    if (bus.lit_count !== 5'd0) begin n_fail++; $display("FAIL rst_gen_lit: got %0d want 0", bus.lit_count); end
    if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL rst_gen_fail: got %b want 0", bus.fail); end
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef BOARD_GEN_SEED_PORT_EN
  task automatic test_seed_load;
    logic [31:0] s;
    bus.seed_load = 1'b1;
    bus.seed = 32'h0;
    @(negedge clk);
    n_checks++;
    if (dut.lfsr_reg !== SEED) begin n_fail++; $display("FAIL seed_zero: got %h want %h", dut.lfsr_reg, SEED); end
    s = $urandom | 32'h1;
    bus.seed = s;
    @(negedge clk);
    n_checks++;
    if (dut.lfsr_reg !== s) begin n_fail++; $display("FAIL seed_value: got %h want %h", dut.lfsr_reg, s); end
    bus.seed_load = 1'b0;
    @(negedge clk);
    $display("seed_load done lfsr=%h", dut.lfsr_reg);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.clear = 1'b0; bus.min_lit = '0; bus.max_lit = '0;
    bus2.start = 1'b0; bus2.clear = 1'b0; bus2.min_lit = '0; bus2.max_lit = '0;
`ifdef BOARD_GEN_SEED_PORT_EN
    bus.seed_load = 1'b0; bus.seed = '0;
    bus2.seed_load = 1'b0; bus2.seed = '0;
`endif
    test_reset();
    test_first_board();
    test_reset_mid_gen();
    test_invalid_window();
    test_max_tries1();
    test_exact_window();
    test_random_windows();
    test_clear();
`ifdef BOARD_GEN_SEED_PORT_EN
    test_seed_load();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
